dvp_capture: RTL and testbench
==============================

DVP_CAPTURE -- requirements
Module: dvp_capture

Interface
REQ-001 SHALL have parameter FRAME_SKIP, default 10, meaning frames discarded after reset before output starts (camera settle).
REQ-002 SHALL have parameter H_ACTIVE, default 1280, meaning expected pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 720, meaning expected lines per frame.
REQ-004 SHALL have parameter VS_POL, default 1, meaning the cam_vsync level that marks vertical blanking.
REQ-005 SHALL have port clk  input  1  camera pixel clock; the only clock in the block.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port cam_vsync  input  1  camera frame sync.
REQ-008 SHALL have port cam_href  input  1  camera line-valid.
REQ-009 SHALL have port cam_data  input  8  camera byte bus, RGB565 sent high byte first.
REQ-010 SHALL have port vin_vs  output  1  frame sync to the video-process stage, active high during blanking.
REQ-011 SHALL have port vin_de  output  1  one-cycle pixel-valid strobe.
REQ-012 SHALL have port vin_data  output  16  RGB565 pixel, valid when vin_de=1.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of each forwarded frame.
REQ-014 SHALL have port size_err  output  1  set when the last forwarded frame's geometry differs from H_ACTIVE x V_ACTIVE.

Function
REQ-015 SHALL register cam_vsync, cam_href and cam_data once on input (stage s1); all logic operates on s1 signals.
REQ-016 SHALL normalise vsync to vs_n = (s1 vsync == VS_POL), and define frame start as a falling edge of vs_n.
REQ-017 SHALL implement FSM WAIT (wait for first frame start), SKIP (count frame starts up to FRAME_SKIP), RUN (forward pixels).
REQ-018 SHALL go WAIT->SKIP on the first frame start; SKIP->RUN on the frame start for which the skip count reaches FRAME_SKIP; with FRAME_SKIP=0, go WAIT->RUN directly.
REQ-019 SHALL stay in RUN until reset.
REQ-020 SHALL keep a byte-phase bit, cleared while href=0, toggled on each href=1 cycle; phase 0 latches the high byte, phase 1 completes the pixel.
REQ-021 SHALL, in RUN, assert vin_de for exactly one cycle with vin_data={high,low}, two cycles after the low byte is at the cam_data pins.
REQ-022 SHALL drive vin_vs as vs_n delayed to align with vin_de (2 cycles after pins).
REQ-023 SHALL keep vin_de=0 in WAIT and SKIP and while vs_n=1.
REQ-024 SHALL count pixels per line (12 bits, saturating at 4095); on the href falling edge, compare the count to H_ACTIVE and increment the line counter (11 bits, saturating).
REQ-025 SHALL treat an href falling edge with phase=1 (odd byte count) as a geometry error and drop the partial byte.
REQ-026 SHALL, on the vs_n rising edge in RUN, pulse frame_done for one cycle and set size_err = (any line mismatch or odd line or line count != V_ACTIVE); size_err SHALL hold until the next frame_done.
REQ-027 SHALL clear the pixel, line and mismatch counters on every frame start.
REQ-028 SHALL, when href is asserted during vs_n=1, ignore the bytes and not count them.
REQ-029 SHALL, when a frame start and an href falling edge occur in the same cycle, apply the frame-start clear (it takes priority).

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, force the FSM to WAIT and clear the skip count, phase, counters and pipeline.
REQ-031 SHALL reset outputs to vin_vs=0, vin_de=0, vin_data=0, frame_done=0, size_err=0.
REQ-032 SHALL, on reset mid-frame, restart frame skipping from zero; no partial pixel is emitted after reset release.

Structure
REQ-033 SHALL place the FSM state encoding (WAIT/SKIP/RUN) and the RGB565 width constant in the shared video package.
REQ-034 SHALL be a single module with no sub-modules; the edge detectors are inline registers.

Verification
REQ-035 SHALL verify: FRAME_SKIP=2, 4 frames of 4x2 -> no vin_de in frames 1-2, and 8 vin_de pulses in each of frames 3 and 4.
REQ-036 SHALL verify: bytes 0xF8,0x1F on consecutive href cycles -> vin_data=16'hF81F with vin_de=1 exactly 2 cycles after the 0x1F byte.
REQ-037 SHALL verify: H_ACTIVE=4, V_ACTIVE=2, a correct frame -> frame_done pulses once and size_err=0; a following frame with one line of 3 pixels -> size_err=1.
REQ-038 SHALL verify: a line with 7 bytes -> 3 pixels output, the 7th byte is dropped, and size_err=1 at frame end.
REQ-039 SHALL verify: rst_n=0 for one cycle mid-line in RUN -> all outputs 0 the next cycle, and output resumes only after FRAME_SKIP new frames.
REQ-040 SHALL verify: VS_POL=0 with inverted vsync stimulus -> output identical to the VS_POL=1 run.

Source files
------------

// File: rtl/dvp_capture_pkg.sv
// Shared video definitions for the DVP capture front end.
// Holds the capture FSM state encoding and the RGB565 pixel width.
// No logic; imported by the capture block.
package dvp_capture_pkg;

    localparam int RGB565_W = 16;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/dvp_capture.sv
// DVP camera capture: pairs RGB565 bytes into pixels, skips settle frames, checks frame geometry.
// Latency: pixel strobe and vsync appear 2 clk cycles after the low byte / vsync is at the pins.
// Backpressure: none; the camera cannot be stalled, so every accepted pixel is forwarded immediately.
module dvp_capture
    import dvp_capture_pkg::*;
#(
    parameter int FRAME_SKIP = 10,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int VS_POL     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [7:0]          cam_data,
    output logic                vin_vs,
    output logic                vin_de,
    output logic [RGB565_W-1:0] vin_data,
    output logic                frame_done,
    output logic                size_err
);

    localparam logic        VS_LVL = (VS_POL != 0);
    localparam logic [15:0] SKIP_N = 16'(FRAME_SKIP);
    localparam logic [11:0] H_EXP  = 12'(H_ACTIVE);
    localparam logic [10:0] V_EXP  = 11'(V_ACTIVE);
    localparam logic [11:0] PIX_MAX  = 12'hFFF;
    localparam logic [10:0] LINE_MAX = 11'h7FF;

    cap_state_e state_q, state_d;
    logic [15:0] skip_cnt_q, skip_cnt_d;

    // input stage s1
    logic        vs1_q, vs1_d;
    logic        href1_q, href1_d;
    logic [7:0]  data1_q, data1_d;

    // edge detector history
    logic        vs_n_prev_q, vs_n_prev_d;
    logic        href_act_prev_q, href_act_prev_d;

    // byte pairing
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;

    // geometry tracking
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic        mism_q, mism_d;
    logic        odd_q, odd_d;

    // outputs
    logic                vin_vs_q, vin_vs_d;
    logic                vin_de_q, vin_de_d;
    logic [RGB565_W-1:0] vin_data_q, vin_data_d;
    logic                frame_done_q, frame_done_d;
    logic                size_err_q, size_err_d;

    // decoded s1 events
    logic vs_n;
    logic frame_start;
    logic frame_end;
    logic href_act;
    logic line_end;
    logic pix_done;

    // Event decode: vs_n is 1 during blanking regardless of camera polarity.
    always_comb begin
        vs_n        = (vs1_q == VS_LVL);
        frame_start = vs_n_prev_q & ~vs_n;
        frame_end   = ~vs_n_prev_q & vs_n;
        // bytes seen during blanking are not part of any line
        href_act    = href1_q & ~vs_n;
        line_end    = href_act_prev_q & ~href1_q & ~vs_n;
        pix_done    = href_act & phase_q;
    end

    // Capture FSM: wait for a frame start, discard FRAME_SKIP frames, then forward forever.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (frame_start) begin
                    skip_cnt_d = 16'd0;
                    state_d    = (FRAME_SKIP == 0) ? ST_RUN : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (frame_start) begin
                    skip_cnt_d = skip_cnt_q + 16'd1;
                    if (skip_cnt_q + 16'd1 == SKIP_N) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_WAIT;
        endcase
    end

    // Datapath: byte pairing, pixel/line counters and frame-end geometry verdict.
    always_comb begin
        vs1_d           = cam_vsync;
        href1_d         = cam_href;
        data1_d         = cam_data;
        vs_n_prev_d     = vs_n;
        href_act_prev_d = href_act;

        phase_d = href_act ? ~phase_q : 1'b0;
        hi_d    = (href_act && !phase_q) ? data1_q : hi_q;

        vin_vs_d   = vs_n;
        vin_de_d   = pix_done && (state_q == ST_RUN);
        vin_data_d = vin_de_d ? {hi_q, data1_q} : vin_data_q;

        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        mism_d     = mism_q;
        odd_d      = odd_q;

        if (pix_done && pix_cnt_q != PIX_MAX) begin
            pix_cnt_d = pix_cnt_q + 12'd1;
        end
        if (line_end) begin
            // an odd byte count leaves phase set; the dangling high byte is simply never used
            mism_d    = mism_q | (pix_cnt_q != H_EXP);
            odd_d     = odd_q | phase_q;
            pix_cnt_d = 12'd0;
            if (line_cnt_q != LINE_MAX) begin
                line_cnt_d = line_cnt_q + 11'd1;
            end
        end
        // frame start wins over a coincident line end
        if (frame_start) begin
            pix_cnt_d  = 12'd0;
            line_cnt_d = 11'd0;
            mism_d     = 1'b0;
            odd_d      = 1'b0;
        end

        frame_done_d = frame_end && (state_q == ST_RUN);
        size_err_d   = size_err_q;
        if (frame_done_d) begin
            size_err_d = mism_q | odd_q | (line_cnt_q != V_EXP);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_WAIT;
            skip_cnt_q      <= 16'd0;
            // park s1 vsync at the active level so reset release never fakes a frame start
            vs1_q           <= ~VS_LVL;
            href1_q         <= 1'b0;
            data1_q         <= 8'd0;
            vs_n_prev_q     <= 1'b0;
            href_act_prev_q <= 1'b0;
            phase_q         <= 1'b0;
            hi_q            <= 8'd0;
            pix_cnt_q       <= 12'd0;
            line_cnt_q      <= 11'd0;
            mism_q          <= 1'b0;
            odd_q           <= 1'b0;
            vin_vs_q        <= 1'b0;
            vin_de_q        <= 1'b0;
            vin_data_q      <= '0;
            frame_done_q    <= 1'b0;
            size_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            skip_cnt_q      <= skip_cnt_d;
            vs1_q           <= vs1_d;
            href1_q         <= href1_d;
            data1_q         <= data1_d;
            vs_n_prev_q     <= vs_n_prev_d;
            href_act_prev_q <= href_act_prev_d;
            phase_q         <= phase_d;
            hi_q            <= hi_d;
            pix_cnt_q       <= pix_cnt_d;
            line_cnt_q      <= line_cnt_d;
            mism_q          <= mism_d;
            odd_q           <= odd_d;
            vin_vs_q        <= vin_vs_d;
            vin_de_q        <= vin_de_d;
            vin_data_q      <= vin_data_d;
            frame_done_q    <= frame_done_d;
            size_err_q      <= size_err_d;
        end
    end

    assign vin_vs     = vin_vs_q;
    assign vin_de     = vin_de_q;
    assign vin_data   = vin_data_q;
    assign frame_done = frame_done_q;
    assign size_err   = size_err_q;

endmodule

// File: tb/tb_dvp_capture.sv
// Scoreboard bench: two captures (VS_POL=1 and VS_POL=0 with inverted vsync) share one stimulus.
// Expected pixels (with arrival cycle) and frame verdicts are queued at drive time.
// Each DUT consumes the same expectation queues through its own read index.
module tb_dvp_capture;

    localparam int FS = 2;
    localparam int HA = 4;
    localparam int VA = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       href;
    logic       vs_pin1;
    logic       vs_pin0;
    logic [7:0] dat;

    logic        vs_o1, de_o1, fd_o1, se_o1;
    logic [15:0] dat_o1;
    logic        vs_o0, de_o0, fd_o0, se_o0;
    logic [15:0] dat_o0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dvp_capture #(.FRAME_SKIP(FS), .H_ACTIVE(HA), .V_ACTIVE(VA), .VS_POL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cam_vsync(vs_pin1), .cam_href(href), .cam_data(dat),
        .vin_vs(vs_o1), .vin_de(de_o1), .vin_data(dat_o1), .frame_done(fd_o1), .size_err(se_o1)
    );

    dvp_capture #(.FRAME_SKIP(FS), .H_ACTIVE(HA), .V_ACTIVE(VA), .VS_POL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cam_vsync(vs_pin0), .cam_href(href), .cam_data(dat),
        .vin_vs(vs_o0), .vin_de(de_o0), .vin_data(dat_o0), .frame_done(fd_o0), .size_err(se_o0)
    );

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } pix_t;

    pix_t       qpix[$];
    logic       fq[$];
    logic [7:0] lbytes[$];

    int   tests = 0;
    int   fails = 0;
    int   rd_p[2];
    int   rd_f[2];
    logic exp_se[2];
    logic fd_prev[2];
    int   de_cnt;

    int   frames_seen;
    logic cur_fwd;
    logic ferr;
    int   nlines;
    int   exp_pix;

    task automatic mon(input int d, input logic de, input logic [15:0] data,
                       input logic fd, input logic se);
        if (de) begin
            tests++;
            assert (rd_p[d] < qpix.size())
            else begin
                fails++;
                $error("FAIL unexpected_pix dut%0d got data=%h at cyc %0d, expected no pixel", d, data, cyc);
            end
            if (rd_p[d] < qpix.size()) begin
                tests++;
                assert (data === qpix[rd_p[d]].data && cyc == qpix[rd_p[d]].cyc)
                else begin
                    fails++;
                    $error("FAIL pix dut%0d got %h@%0d expected %h@%0d", d, data, cyc,
                           qpix[rd_p[d]].data, qpix[rd_p[d]].cyc);
                end
                rd_p[d]++;
            end
            if (d == 1) de_cnt++;
        end
        if (fd) begin
            tests++;
            assert (rd_f[d] < fq.size())
            else begin
                fails++;
                $error("FAIL unexpected_frame_done dut%0d got 1 expected 0", d);
            end
            if (rd_f[d] < fq.size()) begin
                exp_se[d] = fq[rd_f[d]];
                rd_f[d]++;
            end
            tests++;
            assert (!fd_prev[d])
            else begin
                fails++;
                $error("FAIL frame_done_width dut%0d got 2+ cycles expected 1", d);
            end
        end
        fd_prev[d] = fd;
        tests++;
        assert (se === exp_se[d])
        else begin
            fails++;
            $error("FAIL size_err dut%0d got %b expected %b at cyc %0d", d, se, exp_se[d], cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1, de_o1, dat_o1, fd_o1, se_o1);
            mon(0, de_o0, dat_o0, fd_o0, se_o0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_vs(input logic blank);
        vs_pin1 = blank;
        vs_pin0 = ~blank;
    endtask

    task automatic check_zero(input string tag);
        tests++;
        assert ({vs_o1, de_o1, dat_o1, fd_o1, se_o1, vs_o0, de_o0, dat_o0, fd_o0, se_o0} === 40'h0)
        else begin
            fails++;
            $error("FAIL %s got vs=%b de=%b data=%h fd=%b se=%b / vs=%b de=%b data=%h fd=%b se=%b expected all 0",
                   tag, vs_o1, de_o1, dat_o1, fd_o1, se_o1, vs_o0, de_o0, dat_o0, fd_o0, se_o0);
        end
    endtask

    task automatic begin_frame();
        set_vs(1'b1);
        href = 1'b0;
        repeat (4) tick();
        set_vs(1'b0);
        frames_seen++;
        cur_fwd = (frames_seen > FS);
        ferr    = 1'b0;
        nlines  = 0;
        exp_pix = 0;
        de_cnt  = 0;
        repeat (2) tick();
    endtask

    task automatic send_line(input int nb);
        logic [7:0] hi;
        logic [7:0] b;
        hi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            tick();
            b = (lbytes.size() != 0) ? lbytes.pop_front() : 8'($urandom_range(0, 255));
            href = 1'b1;
            dat  = b;
            if (i % 2 == 0) begin
                hi = b;
            end else if (cur_fwd) begin
                qpix.push_back('{data: {hi, b}, cyc: cyc + 2});
                exp_pix++;
            end
        end
        if (nb != 2 * HA) ferr = 1'b1;
        nlines++;
        tick();
        href = 1'b0;
        repeat (2) tick();
    endtask

    task automatic end_frame();
        tick();
        set_vs(1'b1);
        if (cur_fwd) fq.push_back(ferr || (nlines != VA));
        repeat (4) tick();
        tests++;
        assert (de_cnt == exp_pix)
        else begin
            fails++;
            $error("FAIL de_count frame %0d got %0d expected %0d", frames_seen, de_cnt, exp_pix);
        end
    endtask

    initial begin
        rd_p[0] = 0; rd_p[1] = 0;
        rd_f[0] = 0; rd_f[1] = 0;
        exp_se[0] = 1'b0; exp_se[1] = 1'b0;
        fd_prev[0] = 1'b0; fd_prev[1] = 1'b0;
        de_cnt = 0;
        frames_seen = 0;
        cur_fwd = 1'b0;
        ferr = 1'b0;
        nlines = 0;
        exp_pix = 0;

        rst_n = 1'b0;
        href  = 1'b0;
        dat   = 8'h00;
        set_vs(1'b1);
        repeat (3) tick();
        check_zero("reset_state");
        rst_n = 1'b1;
        repeat (3) tick();

        // frames 1-2 are discarded, frame 3 opens with the F8/1F pixel
        for (int f = 0; f < 2; f++) begin
            begin_frame(); send_line(8); send_line(8); end_frame();
        end
        lbytes.push_back(8'hF8);
        lbytes.push_back(8'h1F);
        begin_frame(); send_line(8); send_line(8); end_frame();
        // frame 4 correct geometry
        begin_frame(); send_line(8); send_line(8); end_frame();
        // frame 5: second line only 3 pixels
        begin_frame(); send_line(8); send_line(6); end_frame();
        // frame 6: 7-byte line, last byte dropped
        begin_frame(); send_line(7); send_line(8); end_frame();
        // frame 7: correct again, size_err clears
        begin_frame(); send_line(8); send_line(8); end_frame();
        // frame 8: one line too many
        begin_frame(); send_line(8); send_line(8); send_line(8); end_frame();

        // reset for one cycle mid-line while forwarding
        begin_frame();
        tick(); href = 1'b1; dat = 8'h12;
        tick(); dat = 8'h34;
        qpix.push_back('{data: 16'h1234, cyc: cyc + 2});
        exp_pix++;
        tick(); dat = 8'h56;
        tick(); dat = 8'h78; rst_n = 1'b0;
        tick();
        check_zero("mid_line_reset");
        rst_n = 1'b1;
        frames_seen = 0;
        cur_fwd = 1'b0;
        exp_se[0] = 1'b0;
        exp_se[1] = 1'b0;
        dat = 8'h9A;
        tick(); dat = 8'hBC;
        tick(); href = 1'b0;
        repeat (2) tick();
        end_frame();

        // two skipped frames after reset, then forwarding resumes
        for (int f = 0; f < 3; f++) begin
            begin_frame(); send_line(8); send_line(8); end_frame();
        end

        repeat (5) tick();
        for (int d = 0; d < 2; d++) begin
            tests++;
            assert (rd_p[d] == qpix.size())
            else begin
                fails++;
                $error("FAIL pix_drain dut%0d got %0d expected %0d", d, rd_p[d], qpix.size());
            end
            tests++;
            assert (rd_f[d] == fq.size())
            else begin
                fails++;
                $error("FAIL frame_drain dut%0d got %0d expected %0d", d, rd_f[d], fq.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
